// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between the core memory stage and the data memory
// Ports: Clk, Reset (sync, active-high); ReqValid/ReqWrite/ReqAddr/ReqData request in;
//        ReqReady/Busy/Done handshake out; MemAddr/MemWrEn/MemWrData out and MemRdData in
//        to the data memory; MdrWriteEn/MdrDataIn drive the memory data register.
module mem_access_ctrl #(
    parameter int W      = 8,
    parameter int A      = 8,
    parameter int RD_LAT = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ReqValid,
    input  logic         ReqWrite,
    input  logic [A-1:0] ReqAddr,
    input  logic [W-1:0] ReqData,
    output logic         ReqReady,
    output logic         Busy,
    output logic         Done,
    output logic [A-1:0] MemAddr,
    output logic         MemWrEn,
    output logic [W-1:0] MemWrData,
    input  logic [W-1:0] MemRdData,
    output logic         MdrWriteEn,
    output logic [W-1:0] MdrDataIn
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;
    state_t       state_q;
    logic [A-1:0] addr_q;
    logic [W-1:0] data_q;
    logic         wr_q;
    logic [2:0]   cnt_q;
    logic         ready_q, busy_q, done_q, mem_we_q, mdr_we_q;
    // Handshake and strobes are registered alongside the state so they change only at edges.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mem_we_q <= 1'b0;
            mdr_we_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ReqValid) begin
                    addr_q   <= ReqAddr;
                    data_q   <= ReqData;
                    wr_q     <= ReqWrite;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b1;
                    state_q  <= ReqWrite ? WRITE : READ;
                    done_q   <= ReqWrite;
                    mem_we_q <= ReqWrite;
                    cnt_q    <= 3'(RD_LAT - 1);
                end
                READ: if (cnt_q == 3'd0) begin
                    state_q  <= CAPTURE;
                    done_q   <= 1'b1;
                    mdr_we_q <= ~wr_q;
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
                default: begin
                    state_q  <= IDLE;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    mem_we_q <= 1'b0;
                    mdr_we_q <= 1'b0;
                end
            endcase
        end
    end
    assign ReqReady   = ready_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign MemAddr    = addr_q;
    assign MemWrEn    = mem_we_q;
    assign MemWrData  = mem_we_q ? data_q : '0;
    assign MdrWriteEn = mdr_we_q;
    assign MdrDataIn  = mdr_we_q ? MemRdData : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors for RD_LAT=1 and hand sequences for RD_LAT=3
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    // instance a: RD_LAT=1
    logic       rst_a, v_a, w_a, rdy_a, bsy_a, dn_a, we_a, mwe_a;
    logic [7:0] a_a, d_a, ma_a, wd_a, rd_a, din_a, mdr_a;
    logic [7:0] mem_a [256];
    logic [7:0] pa_a;
    mem_access_ctrl #(.W(8), .A(8), .RD_LAT(1)) dut_a (
        .Clk(clk), .Reset(rst_a), .ReqValid(v_a), .ReqWrite(w_a), .ReqAddr(a_a), .ReqData(d_a),
        .ReqReady(rdy_a), .Busy(bsy_a), .Done(dn_a), .MemAddr(ma_a), .MemWrEn(we_a),
        .MemWrData(wd_a), .MemRdData(rd_a), .MdrWriteEn(mwe_a), .MdrDataIn(din_a));
    always @(posedge clk) begin
        pa_a <= ma_a;
        if (we_a) mem_a[ma_a] <= wd_a;
        if (mwe_a) mdr_a <= din_a;
    end
    assign rd_a = mem_a[pa_a];
    // instance b: RD_LAT=3
    logic       rst_b, v_b, w_b, rdy_b, bsy_b, dn_b, we_b, mwe_b;
    logic [7:0] a_b, d_b, ma_b, wd_b, rd_b, din_b, mdr_b;
    logic [7:0] mem_b [256];
    logic [7:0] pb [3];
    mem_access_ctrl #(.W(8), .A(8), .RD_LAT(3)) dut_b (
        .Clk(clk), .Reset(rst_b), .ReqValid(v_b), .ReqWrite(w_b), .ReqAddr(a_b), .ReqData(d_b),
        .ReqReady(rdy_b), .Busy(bsy_b), .Done(dn_b), .MemAddr(ma_b), .MemWrEn(we_b),
        .MemWrData(wd_b), .MemRdData(rd_b), .MdrWriteEn(mwe_b), .MdrDataIn(din_b));
    always @(posedge clk) begin
        pb[0] <= ma_b;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
        if (we_b) mem_b[ma_b] <= wd_b;
        if (mwe_b) mdr_b <= din_b;
    end
    assign rd_b = mem_b[pb[2]];
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    typedef struct {
        logic v, w;
        logic [7:0] a, d;
        logic rdy, bsy, dn, we;
        logic [7:0] ma, wd;
        logic mwe;
        logic [7:0] din, mdr;
    } vec_t;
    vec_t tv [13];
    initial begin
        tv[0]  = '{1'b1,1'b1,8'h12,8'hA5, 1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,8'h00};
        tv[1]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,1'b1,1'b1,8'h12,8'hA5,1'b0,8'h00,8'h00};
        tv[2]  = '{1'b1,1'b0,8'h40,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h12,8'h00,1'b0,8'h00,8'h00};
        tv[3]  = '{1'b1,1'b1,8'h20,8'h55, 1'b0,1'b1,1'b0,1'b0,8'h40,8'h00,1'b0,8'h00,8'h00};
        tv[4]  = '{1'b1,1'b1,8'h20,8'h55, 1'b0,1'b1,1'b1,1'b0,8'h40,8'h00,1'b1,8'h3C,8'h00};
        tv[5]  = '{1'b1,1'b1,8'h20,8'h55, 1'b1,1'b0,1'b0,1'b0,8'h40,8'h00,1'b0,8'h00,8'h3C};
        tv[6]  = '{1'b1,1'b1,8'hFF,8'h01, 1'b0,1'b1,1'b1,1'b1,8'h20,8'h55,1'b0,8'h00,8'h3C};
        tv[7]  = '{1'b1,1'b1,8'hFF,8'h01, 1'b1,1'b0,1'b0,1'b0,8'h20,8'h00,1'b0,8'h00,8'h3C};
        tv[8]  = '{1'b1,1'b0,8'hFF,8'h00, 1'b0,1'b1,1'b1,1'b1,8'hFF,8'h01,1'b0,8'h00,8'h3C};
        tv[9]  = '{1'b1,1'b0,8'hFF,8'h00, 1'b1,1'b0,1'b0,1'b0,8'hFF,8'h00,1'b0,8'h00,8'h3C};
        tv[10] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,1'b0,1'b0,8'hFF,8'h00,1'b0,8'h00,8'h3C};
        tv[11] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,1'b1,1'b0,8'hFF,8'h00,1'b1,8'h01,8'h3C};
        tv[12] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,8'hFF,8'h00,1'b0,8'h00,8'h01};
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        mem_a[8'h40] = 8'h3C;
        mem_b[8'h07] = 8'hFF;
        mem_b[8'h10] = 8'h99;
        mdr_a = 8'h00;
        mdr_b = 8'h00;
        {v_a, w_a, a_a, d_a} = '0;
        {v_b, w_b, a_b, d_b} = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("a%0d ReqReady", i), {7'd0, rdy_a}, {7'd0, tv[i].rdy});
            chk($sformatf("a%0d Busy", i), {7'd0, bsy_a}, {7'd0, tv[i].bsy});
            chk($sformatf("a%0d Done", i), {7'd0, dn_a}, {7'd0, tv[i].dn});
            chk($sformatf("a%0d MemWrEn", i), {7'd0, we_a}, {7'd0, tv[i].we});
            chk($sformatf("a%0d MemAddr", i), ma_a, tv[i].ma);
            chk($sformatf("a%0d MemWrData", i), wd_a, tv[i].wd);
            chk($sformatf("a%0d MdrWriteEn", i), {7'd0, mwe_a}, {7'd0, tv[i].mwe});
            chk($sformatf("a%0d MdrDataIn", i), din_a, tv[i].din);
            chk($sformatf("a%0d MDR", i), mdr_a, tv[i].mdr);
            {v_a, w_a, a_a, d_a} = {tv[i].v, tv[i].w, tv[i].a, tv[i].d};
            @(posedge clk);
            #1;
        end
        chk("a mem[12]", mem_a[8'h12], 8'hA5);
        chk("a mem[20]", mem_a[8'h20], 8'h55);
        chk("a mem[FF]", mem_a[8'hFF], 8'h01);
        // RD_LAT=3 load: Busy through cycles 1-4, single Done/MdrWriteEn in cycle 4
        chk("b reset ReqReady", {7'd0, rdy_b}, 8'd1);
        chk("b reset Busy", {7'd0, bsy_b}, 8'd0);
        {v_b, w_b, a_b} = {1'b1, 1'b0, 8'h07};
        @(posedge clk);
        #1;
        v_b = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("b c%0d Busy", c), {7'd0, bsy_b}, 8'd1);
            chk($sformatf("b c%0d Done", c), {7'd0, dn_b}, {7'd0, c == 4});
            chk($sformatf("b c%0d MdrWriteEn", c), {7'd0, mwe_b}, {7'd0, c == 4});
            chk($sformatf("b c%0d MdrDataIn", c), din_b, (c == 4) ? 8'hFF : 8'h00);
            chk($sformatf("b c%0d MemAddr", c), ma_b, 8'h07);
            chk($sformatf("b c%0d MemWrEn", c), {7'd0, we_b}, 8'd0);
            @(posedge clk);
            #1;
        end
        chk("b c5 ReqReady", {7'd0, rdy_b}, 8'd1);
        chk("b c5 MDR", mdr_b, 8'hFF);
        // reset in cycle 2 of a READ aborts the load with no strobes afterwards
        {v_b, w_b, a_b} = {1'b1, 1'b0, 8'h10};
        @(posedge clk);
        #1;
        v_b = 1'b0;
        chk("b abort c1 Busy", {7'd0, bsy_b}, 8'd1);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        chk("b abort ReqReady", {7'd0, rdy_b}, 8'd1);
        chk("b abort Busy", {7'd0, bsy_b}, 8'd0);
        chk("b abort Done", {7'd0, dn_b}, 8'd0);
        chk("b abort MemAddr", ma_b, 8'h00);
        chk("b abort MemWrData", wd_b, 8'h00);
        chk("b abort MdrDataIn", din_b, 8'h00);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("b post%0d Done", c), {7'd0, dn_b}, 8'd0);
            chk($sformatf("b post%0d MdrWriteEn", c), {7'd0, mwe_b}, 8'd0);
            @(posedge clk);
            #1;
        end
        chk("b abort MDR", mdr_b, 8'hFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
